// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The state encoding is common to the subtractor and the planned serial adder.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, D = A - B, LSB first through one cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_q;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last;

  full_subtractor u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // DONE accepts a new request exactly like IDLE
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_SHIFT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      d_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
    end else if (accept) begin
      sa     <= A;
      sb     <= B;
      d_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
    end else if (state == S_SHIFT) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      d_q    <= {cell_d, d_q[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      borrow <= cell_bo;
      if (last) bout_q <= cell_bo;
    end
  end

  assign busy  = (state == S_SHIFT);
  assign done  = (state == S_DONE);
  assign D     = d_q;
  assign B_out = bout_q;

endmodule
